// File: rtl/nco_freq_meter.sv
// -----------------------------------------------------------------------------
// nco_freq_meter
//
// Frequency meter sitting at the far end of an NCO sample stream. Rising zero
// crossings are detected with hysteresis: a sample below -HYST arms the
// detector, and the next non-negative sample is the crossing. After an arming
// crossing the meter counts valid samples across N full periods and reports
// the count, so freq = N * fs / period_sum.
//
// Optional feature (macro NCO_FMETER_PEAK_EN): adds peak_pos/peak_neg, the
// signed max/min of the samples seen during the measurement.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset (overrides clken)
//   clken        global clock enable; every register update is qualified by it
//   data_in      NCO sample, signed two's complement, MPR bits
//   data_valid   sample qualifier
//   start        begin a measurement (only honoured while idle)
//   num_periods  periods to measure, 0 treated as 1, latched on accepted start
//   busy         high while arming or measuring
//   period_sum   valid samples spanning N periods, held until the next result
//   meas_valid   one-clken-edge result strobe
//   overflow     last result saturated the sample counter
//   peak_pos     (NCO_FMETER_PEAK_EN) signed maximum during the measurement
//   peak_neg     (NCO_FMETER_PEAK_EN) signed minimum during the measurement
// -----------------------------------------------------------------------------
module nco_freq_meter #(
    parameter int MPR  = 12,
    parameter int CW   = 24,
    parameter int NPW  = 8,
    parameter int HYST = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           clken,
    input  logic [MPR-1:0] data_in,
    input  logic           data_valid,
    input  logic           start,
    input  logic [NPW-1:0] num_periods,
    output logic           busy,
    output logic [CW-1:0]  period_sum,
    output logic           meas_valid,
    output logic           overflow
`ifdef NCO_FMETER_PEAK_EN
    ,
    output logic [MPR-1:0] peak_pos,
    output logic [MPR-1:0] peak_neg
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_MEAS = 2'd2
    } state_t;

    // Arming threshold as a signed sample-width constant.
    localparam logic signed [MPR-1:0] NEG_THR = MPR'(-HYST);
    // Counter value at which one more non-completing sample saturates.
    localparam logic [CW-1:0] SAT_CNT = {{(CW-1){1'b1}}, 1'b0};

    state_t         state_r;
    logic           low_r;
    logic [CW-1:0]  cnt_r;
    logic [NPW-1:0] pcnt_r;
    logic [NPW-1:0] n_r;

    logic           sample_ev_s;
    logic           below_thr_s;
    logic           crossing_s;
    logic [CW-1:0]  cnt_inc_s;
    logic [NPW:0]   pcnt_inc_s;
    logic           last_period_s;
    logic [NPW-1:0] n_eff_s;

    // Sample qualification, crossing detection and next-count arithmetic.
    always_comb begin
        sample_ev_s   = clken & data_valid;
        below_thr_s   = ($signed(data_in) < NEG_THR);
        crossing_s    = sample_ev_s & low_r & ~data_in[MPR-1];
        cnt_inc_s     = cnt_r + {{(CW-1){1'b0}}, 1'b1};
        // One bit wider so the comparison against N can never wrap.
        pcnt_inc_s    = {1'b0, pcnt_r} + {{NPW{1'b0}}, 1'b1};
        last_period_s = (pcnt_inc_s == {1'b0, n_r});
        n_eff_s       = (num_periods == {NPW{1'b0}}) ? {{(NPW-1){1'b0}}, 1'b1}
                                                     : num_periods;
    end

    // Measurement state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            busy       <= 1'b0;
            period_sum <= {CW{1'b0}};
            meas_valid <= 1'b0;
            overflow   <= 1'b0;
            low_r      <= 1'b0;
            cnt_r      <= {CW{1'b0}};
            pcnt_r     <= {NPW{1'b0}};
            n_r        <= {NPW{1'b0}};
`ifdef NCO_FMETER_PEAK_EN
            peak_pos   <= {MPR{1'b0}};
            peak_neg   <= {MPR{1'b0}};
`endif
        end else if (clken) begin
            // Strobe lasts exactly one clken edge.
            meas_valid <= 1'b0;

            // Hysteresis arming flag; an accepted start below overrides it.
            if (crossing_s) begin
                low_r <= 1'b0;
            end else if (sample_ev_s && below_thr_s) begin
                low_r <= 1'b1;
            end

            case (state_r)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        n_r     <= n_eff_s;
                        low_r   <= 1'b0;
                        busy    <= 1'b1;
                        state_r <= ST_ARM;
                    end
                end

                ST_ARM: begin
                    busy <= 1'b1;
                    if (crossing_s) begin
                        cnt_r    <= {CW{1'b0}};
                        pcnt_r   <= {NPW{1'b0}};
                        state_r  <= ST_MEAS;
`ifdef NCO_FMETER_PEAK_EN
                        peak_pos <= data_in;
                        peak_neg <= data_in;
`endif
                    end
                end

                ST_MEAS: begin
                    busy <= 1'b1;
                    if (sample_ev_s) begin
                        cnt_r <= cnt_inc_s;
`ifdef NCO_FMETER_PEAK_EN
                        if ($signed(data_in) > $signed(peak_pos)) begin
                            peak_pos <= data_in;
                        end
                        if ($signed(data_in) < $signed(peak_neg)) begin
                            peak_neg <= data_in;
                        end
`endif
                        if (crossing_s) begin
                            pcnt_r <= pcnt_inc_s[NPW-1:0];
                        end
                        if (crossing_s && last_period_s) begin
                            period_sum <= cnt_inc_s;
                            overflow   <= 1'b0;
                            meas_valid <= 1'b1;
                            busy       <= 1'b0;
                            state_r    <= ST_IDLE;
                        end else if (cnt_r == SAT_CNT) begin
                            period_sum <= {CW{1'b1}};
                            overflow   <= 1'b1;
                            meas_valid <= 1'b1;
                            busy       <= 1'b0;
                            state_r    <= ST_IDLE;
                        end
                    end
                end

                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nco_freq_meter.sv
// -----------------------------------------------------------------------------
// Self-checking bench for nco_freq_meter. Two instances share the sample
// stream: one with the default 24-bit counter and one with a 6-bit counter so
// saturation is reachable. A reference model works on the list of valid
// samples seen since each accepted start: it finds the hysteresis crossings and
// decides completion (Nth crossing after the arming one) or saturation, pushing
// the expected result with the clock edge at which it must appear. A monitor
// pops and compares whenever a fresh meas_valid is presented.
// -----------------------------------------------------------------------------
module tb_nco_freq_meter;

    localparam int HYST  = 16;
    localparam int SAT_A = (1 << 24) - 1;
    localparam int SAT_B = (1 << 6) - 1;
    localparam int BUFSZ = 8192;

    logic        clk = 1'b0;
    logic        reset;
    logic        clken;
    logic        data_valid;
    logic        start_a;
    logic        start_b;
    logic [11:0] data_in;
    logic [7:0]  np_a;
    logic [7:0]  np_b;
    logic        busy_a, mv_a, ov_a;
    logic        busy_b, mv_b, ov_b;
    logic [23:0] ps_a;
    logic [5:0]  ps_b;

    always #5 clk = ~clk;

    nco_freq_meter #(.MPR(12), .CW(24), .NPW(8), .HYST(HYST)) dut_a (
        .clk(clk), .reset(reset), .clken(clken), .data_in(data_in),
        .data_valid(data_valid), .start(start_a), .num_periods(np_a),
        .busy(busy_a), .period_sum(ps_a), .meas_valid(mv_a), .overflow(ov_a)
    );

    nco_freq_meter #(.MPR(12), .CW(6), .NPW(8), .HYST(HYST)) dut_b (
        .clk(clk), .reset(reset), .clken(clken), .data_in(data_in),
        .data_valid(data_valid), .start(start_b), .num_periods(np_b),
        .busy(busy_b), .period_sum(ps_b), .meas_valid(mv_b), .overflow(ov_b)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct { int sum; bit ov; int cyc; } exp_t;
    exp_t eqa[$];
    exp_t eqb[$];

    int  cyc     = 0;
    bit  ce_last = 1'b0;
    bit  m_act[2];
    int  m_n[2];
    int  slen[2];
    int  sbuf[2][BUFSZ];

    // Decide whether the latest sample of instance i ends the measurement.
    function automatic void evalq(input int i, input int n, input int satv,
                                  output bit done, output int sum, output bit ov);
        int cr[$];
        bit armed;
        int j;
        armed = 1'b0;
        done  = 1'b0;
        sum   = 0;
        ov    = 1'b0;
        for (int k = 0; k < slen[i]; k++) begin
            if (armed && sbuf[i][k] >= 0) begin
                cr.push_back(k);
                armed = 1'b0;
            end else if (sbuf[i][k] < -HYST) begin
                armed = 1'b1;
            end
        end
        j = slen[i] - 1;
        if (cr.size() > 0 && j > cr[0]) begin
            if (cr.size() == n + 1 && cr[n] == j) begin
                done = 1'b1;
                sum  = j - cr[0];
            end else if (j - cr[0] == satv) begin
                done = 1'b1;
                sum  = satv;
                ov   = 1'b1;
            end
        end
    endfunction

    task automatic mstep(input int i, input logic st, input logic [7:0] np, input int satv);
        bit   done, ov;
        int   sum;
        exp_t e;
        if (reset) begin
            m_act[i] = 1'b0;
            slen[i]  = 0;
        end else if (clken) begin
            if (!m_act[i]) begin
                if (st) begin
                    m_act[i] = 1'b1;
                    m_n[i]   = (np == 8'd0) ? 1 : int'(np);
                    slen[i]  = 0;
                end
            end else if (data_valid && slen[i] < BUFSZ) begin
                sbuf[i][slen[i]] = int'($signed(data_in));
                slen[i]++;
                evalq(i, m_n[i], satv, done, sum, ov);
                if (done) begin
                    e.sum = sum;
                    e.ov  = ov;
                    e.cyc = cyc;
                    if (i == 0) eqa.push_back(e);
                    else        eqb.push_back(e);
                    m_act[i] = 1'b0;
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc     = cyc + 1;
        ce_last = clken;
        mstep(0, start_a, np_a, SAT_A);
        mstep(1, start_b, np_b, SAT_B);
    end

    // Monitor: a fresh strobe is one seen right after a clken edge.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (ce_last && mv_a) begin
            if (eqa.size() == 0) chk("a_spurious_valid", mv_a, 0);
            else begin
                e = eqa.pop_front();
                chk("a_period_sum", ps_a, e.sum);
                chk("a_overflow", ov_a, e.ov);
                chk("a_latency_edge", cyc, e.cyc);
            end
        end
        if (ce_last && mv_b) begin
            if (eqb.size() == 0) chk("b_spurious_valid", mv_b, 0);
            else begin
                e = eqb.pop_front();
                chk("b_period_sum", ps_b, e.sum);
                chk("b_overflow", ov_b, e.ov);
                chk("b_latency_edge", cyc, e.cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    int wv_period = 16;
    int wv_base   = -800;
    int wv_step   = 100;
    int wv_phase  = 0;
    int vmode     = 0;   // 0 always valid, 1 alternate, 2 random
    int ce_off    = 0;
    bit noise     = 1'b0;
    bit ntog      = 1'b0;
    bit vtog      = 1'b0;
    bit ce_rand   = 1'b0;

    task automatic drive_next();
        int v;
        bit val;
        case (vmode)
            0:       val = 1'b1;
            1:       begin vtog = !vtog; val = vtog; end
            default: val = ($urandom_range(0, 1) == 1);
        endcase
        clken = ce_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (ce_off > 0) begin
            clken  = 1'b0;
            ce_off = ce_off - 1;
        end
        if (noise) v = ntog ? 10 : -10;
        else       v = wv_base + wv_step * wv_phase;
        data_in    = v[11:0];
        data_valid = val;
        if (clken && val) begin
            if (noise) ntog = !ntog;
            else       wv_phase = (wv_phase + 1) % wv_period;
        end
    endtask

    task automatic step();
        @(negedge clk);
        drive_next();
    endtask

    task automatic pulse_start(input bit which, input logic [7:0] n);
        if (which) begin start_b = 1'b1; np_b = n; end
        else       begin start_a = 1'b1; np_a = n; end
        clken = 1'b1;
        step();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic wait_res(input bit which, input int budget, input string nm, output bit got);
        got = 1'b0;
        for (int k = 0; k < budget && !got; k++) begin
            step();
            if (ce_last && (which ? mv_b : mv_a)) got = 1'b1;
        end
        if (!got) chk({nm, "_timeout"}, which ? mv_b : mv_a, 1);
    endtask

    task automatic set_ramp(input int period);
        noise     = 1'b0;
        wv_period = period;
        wv_base   = -(period / 2) * 100;
        wv_phase  = 0;
    endtask

    initial begin
        bit got;
        reset = 1'b1; clken = 1'b1; data_valid = 1'b0; data_in = 12'd0;
        start_a = 1'b0; start_b = 1'b0; np_a = 8'd0; np_b = 8'd0;
        set_ramp(16);
        repeat (3) step();
        chk("rst_busy", busy_a, 0);
        chk("rst_sum", ps_a, 0);
        chk("rst_valid", mv_a, 0);
        chk("rst_ovf", ov_a, 0);
        chk("rst_b_busy", busy_b, 0);
        reset = 1'b0;
        repeat (5) step();

        // 16-sample ramp, four periods
        pulse_start(0, 8'd4);
        chk("t1_busy_start", busy_a, 1);
        wait_res(0, 200, "t1", got);
        if (got) begin
            chk("t1_sum", ps_a, 64);
            chk("t1_ovf", ov_a, 0);
            step();
            chk("t1_pulse_end", mv_a, 0);
            chk("t1_busy_end", busy_a, 0);
            chk("t1_sum_hold", ps_a, 64);
        end

        // every other cycle invalid
        vmode = 1;
        pulse_start(0, 8'd4);
        wait_res(0, 400, "t2", got);
        if (got) chk("t2_sum", ps_a, 64);
        vmode = 0;

        // sub-threshold noise never crosses, then the real ramp
        noise = 1'b1;
        pulse_start(0, 8'd4);
        repeat (40) step();
        chk("t3_busy_noise", busy_a, 1);
        chk("t3_no_valid", mv_a, 0);
        set_ramp(16);
        wait_res(0, 200, "t3", got);
        if (got) chk("t3_sum", ps_a, 64);

        // narrow counter saturates: 40-sample period, two periods
        set_ramp(40);
        step();
        pulse_start(1, 8'd2);
        wait_res(1, 300, "t4", got);
        if (got) begin
            chk("t4_sum", ps_b, 63);
            chk("t4_ovf", ov_b, 1);
            step();
            chk("t4_pulse_end", mv_b, 0);
            chk("t4_busy_end", busy_b, 0);
        end

        // reset mid-measurement, then N=0 treated as 1
        set_ramp(16);
        pulse_start(0, 8'd4);
        repeat (30) step();
        chk("t5_busy_meas", busy_a, 1);
        reset = 1'b1;
        step();
        chk("t5_rst_busy", busy_a, 0);
        chk("t5_rst_sum", ps_a, 0);
        chk("t5_rst_valid", mv_a, 0);
        chk("t5_rst_b_sum", ps_b, 0);
        chk("t5_rst_b_ovf", ov_b, 0);
        reset = 1'b0;
        pulse_start(0, 8'd0);
        wait_res(0, 200, "t5", got);
        if (got) chk("t5_sum_n0", ps_a, 16);

        // restart attempt while busy is ignored; clken gap mid-measurement
        pulse_start(0, 8'd4);
        repeat (20) step();
        pulse_start(0, 8'd1);
        repeat (10) step();
        chk("t6_busy", busy_a, 1);
        ce_off = 5;
        wait_res(0, 200, "t6", got);
        if (got) chk("t6_sum", ps_a, 64);

        // randomized periods, N, valid pattern and clock-enable gaps
        vmode   = 2;
        ce_rand = 1'b1;
        for (int r = 0; r < 6; r++) begin
            int  budget;
            logic [7:0] na, nb;
            set_ramp($urandom_range(8, 24));
            wv_phase = $urandom_range(0, wv_period - 1);
            na = 8'($urandom_range(0, 5));
            nb = 8'($urandom_range(0, 3));
            start_b = 1'b1; np_b = nb;
            pulse_start(0, na);
            budget = 0;
            while ((busy_a || busy_b) && budget < 4000) begin
                step();
                budget++;
            end
            if (budget >= 4000) chk("t7_done", busy_a | busy_b, 0);
            repeat (2) step();
        end
        ce_rand = 1'b0;
        vmode   = 0;

        repeat (4) step();
        chk("a_pending_results", eqa.size(), 0);
        chk("b_pending_results", eqb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
